// File: rtl/mem_access_ctrl_if.sv
// Request/response and memory-side signals of the data-memory access controller.
// The master side is the requester/memory environment; the slave side is the controller.
interface mem_access_ctrl_if;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [7:0]  ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_ack;
  logic [15:0] ls_rdata;
  logic [7:0]  pc_addr_q;
  logic [7:0]  ls_addr_q;
  logic        addr_sel;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_ack, if_rdata, ls_ack, ls_rdata, pc_addr_q, ls_addr_q,
           addr_sel, mem_en, mem_we, mem_wdata, busy
  );

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_ack, if_rdata, ls_ack, ls_rdata, pc_addr_q, ls_addr_q,
           addr_sel, mem_en, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: arbitrates fetch vs load/store onto a single-port
// memory, owns the address-mux select and the registered mux inputs, issues a
// one-cycle strobe, waits MEM_LAT cycles and returns data with a one-cycle ack.
// Load/store wins unless it has already taken MAX_STREAK grants in a row while
// fetch was waiting.
module mem_access_ctrl #(
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic        win_we_q, win_we_d;
  logic        if_ack_q, if_ack_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic        ls_ack_q, ls_ack_d;
  logic [15:0] ls_rdata_q, ls_rdata_d;
  logic [7:0]  pc_addr_q, pc_addr_d;
  logic [7:0]  ls_addr_q, ls_addr_d;
  logic        addr_sel_q, addr_sel_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;

  logic grant_ls, grant_if, wait_last;

  // Requests are only looked at in IDLE; fetch overrides once the streak is used up.
  assign grant_ls  = (state_q == IDLE) && bus.ls_req &&
                     (!bus.if_req || (streak_q < STREAK_MAX));
  assign grant_if  = (state_q == IDLE) && !grant_ls && bus.if_req;
  assign wait_last = (state_q == WAIT) && (wcnt_q == 3'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing: one ACCESS cycle, MEM_LAT WAIT cycles, one DONE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_ls || grant_if) state_d = ACCESS;
      ACCESS:  state_d = WAIT;
      WAIT:    if (wcnt_q == 3'd1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of all registered outputs and bookkeeping. addr_sel_q doubles as
  // the record of which requester owns the current access, since it only moves on a grant.
  always_comb begin
    streak_d    = streak_q;
    wcnt_d      = wcnt_q;
    win_we_d    = win_we_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    pc_addr_d   = pc_addr_q;
    ls_addr_d   = ls_addr_q;
    addr_sel_d  = addr_sel_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    busy_d      = (state_d != IDLE);

    if (grant_ls) begin
      ls_addr_d   = bus.ls_addr;
      addr_sel_d  = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = bus.ls_we;
      mem_wdata_d = bus.ls_wdata;
      win_we_d    = bus.ls_we;
      if (!bus.if_req)                streak_d = '0;
      else if (streak_q < STREAK_MAX) streak_d = streak_q + 4'd1;
    end else if (grant_if) begin
      pc_addr_d  = bus.if_addr;
      addr_sel_d = 1'b0;
      mem_en_d   = 1'b1;
      win_we_d   = 1'b0;
      streak_d   = '0;
    end

    if (state_q == ACCESS) wcnt_d = LAT_INIT;
    if (state_q == WAIT)   wcnt_d = wcnt_q - 3'd1;

    if (wait_last) begin
      if (addr_sel_q) begin
        ls_ack_d = 1'b1;
        if (!win_we_q) ls_rdata_d = bus.mem_rdata;
      end else begin
        if_ack_d   = 1'b1;
        if_rdata_d = bus.mem_rdata;
      end
    end
  end

  // Output and bookkeeping registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q    <= '0;
      wcnt_q      <= '0;
      win_we_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      pc_addr_q   <= '0;
      ls_addr_q   <= '0;
      addr_sel_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      streak_q    <= streak_d;
      wcnt_q      <= wcnt_d;
      win_we_q    <= win_we_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      pc_addr_q   <= pc_addr_d;
      ls_addr_q   <= ls_addr_d;
      addr_sel_q  <= addr_sel_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.pc_addr_q = pc_addr_q;
  assign bus.ls_addr_q = ls_addr_q;
  assign bus.addr_sel  = addr_sel_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: three instances with MEM_LAT = 1, 3, 7 (MAX_STREAK = 3),
// directed transaction table, arbitration and reset sequences, then random traffic,
// all shadowed by a transaction-phase reference model.
module tb_mem_access_ctrl;

  localparam int MAXS = 3;

  typedef struct packed {
    logic        if_req;
    logic [7:0]  if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [7:0]  ls_addr;
    logic [15:0] ls_wdata;
    logic [15:0] mem_rdata;
  } drv_t;

  typedef struct packed {
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        ls_ack;
    logic [15:0] ls_rdata;
    logic [7:0]  pc_addr_q;
    logic [7:0]  ls_addr_q;
    logic        addr_sel;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic        busy;
  } obs_t;

  // Model state: act = access in flight, t = edges since the grant edge.
  typedef struct packed {
    bit   act;
    int   t;
    int   streak;
    bit   wl;
    bit   ww;
    obs_t e;
  } mstate_t;

  typedef struct packed {
    bit          is_ls;
    bit          we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    bit          exp_sel;
    bit          exp_we;
    bit          exp_upd;
  } vec_t;

  logic       clk = 1'b0;
  logic [2:0] rst_n_v;
  drv_t       drv [3];
  obs_t       obs [3];
  mstate_t    ms  [3];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 7;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int LAT = (k == 0) ? 1 : (k == 1) ? 3 : 7;
    mem_access_ctrl_if bus ();
    assign bus.if_req    = drv[k].if_req;
    assign bus.if_addr   = drv[k].if_addr;
    assign bus.ls_req    = drv[k].ls_req;
    assign bus.ls_we     = drv[k].ls_we;
    assign bus.ls_addr   = drv[k].ls_addr;
    assign bus.ls_wdata  = drv[k].ls_wdata;
    assign bus.mem_rdata = drv[k].mem_rdata;
    assign obs[k] = '{if_ack: bus.if_ack, if_rdata: bus.if_rdata, ls_ack: bus.ls_ack,
                      ls_rdata: bus.ls_rdata, pc_addr_q: bus.pc_addr_q,
                      ls_addr_q: bus.ls_addr_q, addr_sel: bus.addr_sel,
                      mem_en: bus.mem_en, mem_we: bus.mem_we,
                      mem_wdata: bus.mem_wdata, busy: bus.busy};
    mem_access_ctrl #(.MEM_LAT(LAT), .MAX_STREAK(MAXS)) u_dut (
      .clk   (clk),
      .rst_n (rst_n_v[k]),
      .bus   (bus)
    );
  end

  // Reference: one step per clock edge from the access-timeline rules.
  function automatic mstate_t step(input mstate_t m, input drv_t d, input logic rn, input int lat);
    mstate_t n;
    n = m;
    if (!rn) begin
      n = '0;
      return n;
    end
    n.e.if_ack = 1'b0;
    n.e.ls_ack = 1'b0;
    n.e.mem_en = 1'b0;
    n.e.mem_we = 1'b0;
    if (!m.act) begin
      if (d.ls_req && (!d.if_req || m.streak < MAXS)) begin
        n.act = 1'b1; n.t = 0; n.wl = 1'b1; n.ww = d.ls_we;
        n.e.addr_sel = 1'b1; n.e.ls_addr_q = d.ls_addr;
        n.e.mem_en = 1'b1; n.e.mem_we = d.ls_we; n.e.mem_wdata = d.ls_wdata;
        n.streak = d.if_req ? m.streak + 1 : 0;
      end else if (d.if_req) begin
        n.act = 1'b1; n.t = 0; n.wl = 1'b0; n.ww = 1'b0;
        n.e.addr_sel = 1'b0; n.e.pc_addr_q = d.if_addr;
        n.e.mem_en = 1'b1;
        n.streak = 0;
      end
    end else begin
      n.t = m.t + 1;
      if (n.t == lat + 1) begin
        if (m.wl) begin
          n.e.ls_ack = 1'b1;
          if (!m.ww) n.e.ls_rdata = d.mem_rdata;
        end else begin
          n.e.if_ack   = 1'b1;
          n.e.if_rdata = d.mem_rdata;
        end
      end else if (n.t == lat + 2) begin
        n.act = 1'b0;
      end
    end
    n.e.busy = n.act;
    return n;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) ms[k] <= step(ms[k], drv[k], rst_n_v[k], lat_of(k));
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs[k] !== ms[k].e) begin
        n_errors++;
        $display("FAIL model_cmp inst%0d t=%0t: got %h want %h", k, $time, obs[k], ms[k].e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  logic [15:0] exp_if_rd [3];
  logic [15:0] exp_ls_rd [3];
  logic [7:0]  exp_pc    [3];
  logic [7:0]  exp_lsa   [3];

  task automatic do_txn(input int k, input vec_t v);
    int lat, gs, as;
    lat = lat_of(k);
    gs = -1;
    as = -1;
    @(negedge clk);
    if (v.is_ls) begin
      drv[k].ls_req = 1'b1; drv[k].ls_we = v.we;
      drv[k].ls_addr = v.addr; drv[k].ls_wdata = v.wdata;
    end else begin
      drv[k].if_req = 1'b1; drv[k].if_addr = v.addr;
    end
    drv[k].mem_rdata = 16'($urandom);
    for (int n = 1; n <= 40 && as < 0; n++) begin
      @(negedge clk);
      if (gs < 0 && obs[k].mem_en) begin
        gs = n;
        if (v.is_ls) exp_lsa[k] = v.addr;
        else         exp_pc[k]  = v.addr;
        check($sformatf("txn%0d_addr_sel", k), 32'(obs[k].addr_sel), 32'(v.exp_sel));
        check($sformatf("txn%0d_mem_we", k), 32'(obs[k].mem_we), 32'(v.exp_we));
        check($sformatf("txn%0d_pc_addr_q", k), 32'(obs[k].pc_addr_q), 32'(exp_pc[k]));
        check($sformatf("txn%0d_ls_addr_q", k), 32'(obs[k].ls_addr_q), 32'(exp_lsa[k]));
        if (v.is_ls) check($sformatf("txn%0d_mem_wdata", k), 32'(obs[k].mem_wdata), 32'(v.wdata));
      end else if (gs >= 0 && n == gs + 1) begin
        check($sformatf("txn%0d_strobe_1cyc", k), {30'b0, obs[k].mem_en, obs[k].mem_we}, 32'd0);
      end
      if (obs[k].if_ack || obs[k].ls_ack) begin
        as = n;
        check($sformatf("txn%0d_ack_which", k), {30'b0, obs[k].ls_ack, obs[k].if_ack},
              v.is_ls ? 32'd2 : 32'd1);
        drv[k].if_req = 1'b0;
        drv[k].ls_req = 1'b0;
      end
      drv[k].mem_rdata = (gs >= 0 && n == gs + lat) ? v.rdata : 16'($urandom);
    end
    if (gs < 0 || as < 0) begin
      check($sformatf("txn%0d_timeout", k), 32'd1, 32'd0);
      drv[k].if_req = 1'b0;
      drv[k].ls_req = 1'b0;
    end else begin
      if (v.exp_upd) begin
        if (v.is_ls) exp_ls_rd[k] = v.rdata;
        else         exp_if_rd[k] = v.rdata;
      end
      check($sformatf("txn%0d_latency", k), 32'(as - gs), 32'(lat + 1));
      check($sformatf("txn%0d_if_rdata", k), 32'(obs[k].if_rdata), 32'(exp_if_rd[k]));
      check($sformatf("txn%0d_ls_rdata", k), 32'(obs[k].ls_rdata), 32'(exp_ls_rd[k]));
    end
  endtask

  vec_t tbl [7];
  bit   arb_exp [8];

  initial begin : main
    int ng, last_g, gnt, ack_at;
    bit done, re_if, re_ls;

    tbl[0] = '{is_ls:1'b0, we:1'b0, addr:8'h10, wdata:16'h0000, rdata:16'hBEEF, exp_sel:1'b0, exp_we:1'b0, exp_upd:1'b1};
    tbl[1] = '{is_ls:1'b1, we:1'b1, addr:8'h80, wdata:16'h1234, rdata:16'hDEAD, exp_sel:1'b1, exp_we:1'b1, exp_upd:1'b0};
    tbl[2] = '{is_ls:1'b1, we:1'b0, addr:8'h81, wdata:16'h0F0F, rdata:16'h5A5A, exp_sel:1'b1, exp_we:1'b0, exp_upd:1'b1};
    tbl[3] = '{is_ls:1'b0, we:1'b0, addr:8'hFF, wdata:16'h0000, rdata:16'h0001, exp_sel:1'b0, exp_we:1'b0, exp_upd:1'b1};
    tbl[4] = '{is_ls:1'b1, we:1'b1, addr:8'h00, wdata:16'hFFFF, rdata:16'h7777, exp_sel:1'b1, exp_we:1'b1, exp_upd:1'b0};
    tbl[5] = '{is_ls:1'b1, we:1'b0, addr:8'hFF, wdata:16'hAAAA, rdata:16'hA55A, exp_sel:1'b1, exp_we:1'b0, exp_upd:1'b1};
    tbl[6] = '{is_ls:1'b0, we:1'b0, addr:8'h00, wdata:16'h0000, rdata:16'hFFFF, exp_sel:1'b0, exp_we:1'b0, exp_upd:1'b1};
    arb_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset held with both requests up.
    rst_n_v = '0;
    for (int k = 0; k < 3; k++) begin
      drv[k] = '0;
      drv[k].if_req = 1'b1; drv[k].if_addr = 8'h55;
      drv[k].ls_req = 1'b1; drv[k].ls_addr = 8'hAA; drv[k].ls_we = 1'b1;
      exp_if_rd[k] = '0; exp_ls_rd[k] = '0; exp_pc[k] = '0; exp_lsa[k] = '0;
    end
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        check($sformatf("reset_outputs_zero%0d", k), 32'(obs[k] === obs_t'('0)), 32'd1);
    end
    for (int k = 0; k < 3; k++) drv[k] = '0;
    rst_n_v = '1;

    // Directed transaction table on every latency.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 7; i++) do_txn(k, tbl[i]);

    // Arbitration with both requesters continuously busy (MEM_LAT=1 instance).
    @(negedge clk); rst_n_v[0] = 1'b0;
    @(negedge clk); rst_n_v[0] = 1'b1;
    drv[0].if_req = 1'b1; drv[0].if_addr = 8'h21;
    drv[0].ls_req = 1'b1; drv[0].ls_we = 1'b0; drv[0].ls_addr = 8'h42;
    ng = 0; last_g = -1; done = 1'b0; re_if = 1'b0; re_ls = 1'b0;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(negedge clk);
      if (re_if) begin drv[0].if_req = 1'b1; re_if = 1'b0; end
      if (re_ls) begin drv[0].ls_req = 1'b1; re_ls = 1'b0; end
      if (obs[0].mem_en) begin
        if (ng < 8) check($sformatf("arb_grant%0d_sel", ng), 32'(obs[0].addr_sel), 32'(arb_exp[ng]));
        if (last_g >= 0) check("arb_grant_gap", 32'(n - last_g), 32'(lat_of(0) + 3));
        last_g = n;
        ng++;
      end
      if (obs[0].if_ack) begin drv[0].if_req = 1'b0; re_if = 1'b1; end
      if (obs[0].ls_ack) begin drv[0].ls_req = 1'b0; re_ls = 1'b1; end
      if (ng >= 8 && (obs[0].if_ack || obs[0].ls_ack)) begin
        drv[0].if_req = 1'b0; drv[0].ls_req = 1'b0; done = 1'b1;
      end
    end
    check("arb_complete", 32'(done), 32'd1);
    repeat (3) @(negedge clk);

    // Reset during WAIT (MEM_LAT=3 instance), request kept high throughout.
    @(negedge clk);
    drv[1].if_req = 1'b1; drv[1].if_addr = 8'h33; drv[1].mem_rdata = 16'hC0DE;
    gnt = 0;
    for (int n = 1; n <= 20 && gnt == 0; n++) begin
      @(negedge clk);
      if (obs[1].mem_en) gnt = 1;
    end
    check("rstmid_first_grant", 32'(gnt), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n_v[1] = 1'b0;
    @(negedge clk);
    check("rstmid_outputs_zero", 32'(obs[1] === obs_t'('0)), 32'd1);
    check("rstmid_no_ack", 32'(obs[1].if_ack), 32'd0);
    check("rstmid_busy", 32'(obs[1].busy), 32'd0);
    rst_n_v[1] = 1'b1;
    @(negedge clk);
    check("rstmid_regrant", 32'(obs[1].mem_en), 32'd1);
    check("rstmid_regrant_addr", 32'(obs[1].pc_addr_q), 32'h33);
    ack_at = -1;
    for (int n = 1; n <= 20 && ack_at < 0; n++) begin
      @(negedge clk);
      if (obs[1].if_ack) ack_at = n;
    end
    check("rstmid_ack_latency", 32'(ack_at), 32'(lat_of(1) + 1));
    check("rstmid_if_rdata", 32'(obs[1].if_rdata), 32'hC0DE);
    drv[1].if_req = 1'b0;
    repeat (3) @(negedge clk);

    // Random traffic with occasional resets; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n_v[k]) rst_n_v[k] = 1'b1;
        else if ($urandom_range(0, 299) == 0) rst_n_v[k] = 1'b0;
        if (drv[k].if_req && obs[k].if_ack) drv[k].if_req = 1'b0;
        else if (!drv[k].if_req && $urandom_range(0, 2) == 0) begin
          drv[k].if_req = 1'b1; drv[k].if_addr = 8'($urandom);
        end
        if (drv[k].ls_req && obs[k].ls_ack) drv[k].ls_req = 1'b0;
        else if (!drv[k].ls_req && $urandom_range(0, 2) == 0) begin
          drv[k].ls_req = 1'b1; drv[k].ls_we = 1'($urandom);
          drv[k].ls_addr = 8'($urandom); drv[k].ls_wdata = 16'($urandom);
        end
        drv[k].mem_rdata = 16'($urandom);
      end
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      drv[k].if_req = 1'b0;
      drv[k].ls_req = 1'b0;
    end
    rst_n_v = '1;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences the processor's single-port 8-bit-address data memory between two requesters: instruction fetch (PC address) and load/store (memory address). It owns the D_ADDR_MUX select and registers the addresses feeding the mux (data0 = fetch, data1 = load/store). It also issues the one-cycle memory strobe, waits a fixed read latency and returns data with a one-cycle acknowledge. Load/store has priority, bounded by a streak limit so fetch cannot starve.

Parameters:
MEM_LAT, 1, memory read latency in cycles from strobe-sampling edge to valid mem_rdata; legal 1..7
MAX_STREAK, 3, maximum consecutive load/store grants while fetch is waiting; legal 1..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
if_req  input  1  fetch request, level, held until if_ack
if_addr  input  8  fetch address, stable while if_req high
if_ack  output  1  one-cycle fetch completion pulse
if_rdata  output  16  fetched instruction, valid when if_ack high, held after
ls_req  input  1  load/store request, level, held until ls_ack
ls_we  input  1  1 = store, 0 = load; stable while ls_req high
ls_addr  input  8  load/store address
ls_wdata  input  16  store data
ls_ack  output  1  one-cycle load/store completion pulse
ls_rdata  output  16  load data, valid when ls_ack high, held after
pc_addr_q  output  8  registered fetch address, drives mux data0
ls_addr_q  output  8  registered load/store address, drives mux data1
addr_sel  output  1  mux select: 0 = PC address, 1 = memory address
mem_en  output  1  memory access strobe, one cycle per access
mem_we  output  1  memory write enable, only high together with mem_en
mem_wdata  output  16  store data to memory
mem_rdata  input  16  memory read data
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs registered. On reset: state IDLE, all outputs 0, streak counter 0, wait counter 0.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE grant rule, evaluated at each edge in IDLE:
  - Grant LS if ls_req and (!if_req or streak < MAX_STREAK).
  - Otherwise grant IF if if_req.
  - Otherwise stay in IDLE.
- Grant edge (E0), entering ACCESS:
  - Winner's address is latched into its _addr_q register.
  - addr_sel = 1 for LS, 0 for IF.
  - mem_en = 1.
  - For LS: mem_we = ls_we and mem_wdata = ls_wdata.
  - The other _addr_q holds its value.
- ACCESS lasts one cycle. Memory samples the strobe at E1. Then mem_en = 0, mem_we = 0, wait counter = MEM_LAT, and the controller enters WAIT.
- WAIT: the counter decrements each edge. At the edge where it reaches 0 (E1+MEM_LAT):
  - mem_rdata is captured into the winner's _rdata.
  - The winner's _ack goes high for one cycle.
  - The controller enters DONE.
  - Request-to-ack latency is MEM_LAT+1 edges after E0.
- Stores complete with the same timing; ls_rdata is not updated on a store.
- DONE lasts one cycle with ack high. No grant is made in DONE, even if a request is high. Next state is IDLE. Minimum period between grants is MEM_LAT+3 cycles.
- Streak counter:
  - Increments, saturating at MAX_STREAK, on each LS grant made while if_req is high.
  - Clears to 0 on any IF grant, and on an LS grant with if_req low.
- addr_sel, pc_addr_q and ls_addr_q hold their last values through WAIT, DONE and IDLE. addr_sel changes only on a grant edge.
- Requests are sampled only in IDLE. Changes to req or addr during ACCESS, WAIT or DONE are ignored.
- Reset asserted in any state takes effect at the next edge: the access is abandoned, no ack is issued and all outputs are cleared.
- Both acks are never high in the same cycle. mem_en is never high for more than one consecutive cycle.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with if_req=ls_req=1 -> all outputs 0, busy=0, no mem_en.
- Fetch (MEM_LAT=1): if_req=1, if_addr=0x10, mem_rdata=0xBEEF -> mem_en high exactly 1 cycle with addr_sel=0 and pc_addr_q=0x10; if_ack pulses 2 edges after grant; if_rdata=0xBEEF; next grant no sooner than 4 cycles after the previous one.
- Store: ls_req=1, ls_we=1, ls_addr=0x80, ls_wdata=0x1234 -> addr_sel=1, ls_addr_q=0x80, mem_en=mem_we=1 for one cycle with mem_wdata=0x1234; ls_ack pulses; ls_rdata unchanged.
- Arbitration (MAX_STREAK=3): if_req and ls_req both held, each re-raised the cycle after its ack -> grant order LS, LS, LS, IF, LS, LS, LS, IF; addr_sel toggles accordingly.
- Reset mid-operation (MEM_LAT=3): rst_n=0 for one cycle during WAIT -> no ack, outputs 0, busy=0; a held request is re-granted from IDLE.
- Latency sweep MEM_LAT=1,3,7: ack edge = grant edge + MEM_LAT+1; rdata matches the mem_rdata presented at that edge.
